// File: rtl/wave_capture.sv
// Wave capture: waits for a negative-to-non-negative zero crossing, then fills
// one half of a double-buffered sample RAM while the display reads the other half.
module wave_capture #(
  parameter int NUM_SAMPLES = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_sample_ready,
  input  logic [15:0]                    new_sample_in,
  input  logic                           wave_display_idle,
  output logic [$clog2(NUM_SAMPLES):0]   write_address,
  output logic                           write_enable,
  output logic [7:0]                     write_sample,
  output logic                           read_index
);

  localparam int CW = $clog2(NUM_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] count, next_count;
  logic          prev_neg, next_prev_neg;
  logic          next_read_index;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARMED;
      count      <= '0;
      prev_neg   <= 1'b0;
      read_index <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= next_count;
      prev_neg   <= next_prev_neg;
      read_index <= next_read_index;
    end
  end

  always_comb begin
    next_state      = state;
    next_count      = count;
    next_prev_neg   = prev_neg;
    next_read_index = read_index;
    write_enable    = 1'b0;
    case (state)
      ARMED: begin
        if (new_sample_ready) begin
          next_prev_neg = new_sample_in[15];
          // Zero counts as non-negative, so a negative-then-zero pair triggers.
          if (prev_neg && !new_sample_in[15]) begin
            next_state = ACTIVE;
            next_count = '0;
          end
        end
      end
      ACTIVE: begin
        write_enable = new_sample_ready;
        if (new_sample_ready) begin
          next_count = count + CW'(1);
          if (count == LAST) next_state = WAIT;
        end
      end
      WAIT: begin
        // Swap only while the display is off the wave region; samples are dropped here.
        if (wave_display_idle) begin
          next_read_index = ~read_index;
          next_prev_neg   = 1'b0;
          next_state      = ARMED;
        end
      end
      default: next_state = ARMED;
    endcase
  end

  assign write_address = {~read_index, count};
  assign write_sample  = {~new_sample_in[15], new_sample_in[14:8]};

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = 16'h0000;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int n_vec = 0;
  int n_fail = 0;

  // Behavioural model: capture phase, samples stored so far, last sign, display half.
  int m_phase;   // 0 waiting for crossing, 1 capturing, 2 holding full buffer
  int m_written;
  bit m_last_neg;
  bit m_front;

  typedef struct {
    logic        nsr;
    logic [15:0] smp;
    logic        idle;
    logic        exp_we;
    logic [8:0]  exp_addr;
    logic [7:0]  exp_ws;
  } vec_t;

  vec_t vecs[6];

  wave_capture #(.NUM_SAMPLES(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_ws(input logic [15:0] s);
    int v;
    v = int'($signed(s));
    v = (v >>> 8) + 128;
    return v[7:0];
  endfunction

  function automatic logic [8:0] model_addr();
    int a;
    a = (m_front ? 0 : 256) + (m_written % 256);
    return a[8:0];
  endfunction

  task automatic model_reset();
    m_phase    = 0;
    m_written  = 0;
    m_last_neg = 1'b0;
    m_front    = 1'b0;
  endtask

  task automatic model_clock();
    bit neg;
    neg = ($signed(new_sample_in) < 0);
    case (m_phase)
      0: if (new_sample_ready) begin
           if (m_last_neg && !neg) begin
             m_phase   = 1;
             m_written = 0;
           end
           m_last_neg = neg;
         end
      1: if (new_sample_ready) begin
           m_written++;
           if (m_written == 256) begin
             m_phase   = 2;
             m_written = 0;
           end
         end
      default: if (wave_display_idle) begin
           m_front    = ~m_front;
           m_phase    = 0;
           m_last_neg = 1'b0;
         end
    endcase
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge and move to the falling edge for sampling.
  task automatic apply_stimulus(input logic nsr, input logic [15:0] smp, input logic idle);
    new_sample_ready  = nsr;
    new_sample_in     = smp;
    wave_display_idle = idle;
    @(negedge clk);
  endtask

  task automatic commit_cycle();
    @(posedge clk);
    if (!reset) model_clock();
    #1;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".we"},   16'(write_enable),  16'(m_phase == 1 && new_sample_ready));
    check_output({tag, ".addr"}, 16'(write_address), 16'(model_addr()));
    check_output({tag, ".ws"},   16'(write_sample),  16'(model_ws(new_sample_in)));
  endtask

  task automatic step(input string tag, input logic nsr, input logic [15:0] smp, input logic idle);
    apply_stimulus(nsr, smp, idle);
    check_model(tag);
    commit_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    #1;
    model_reset();
    check_output("reset.we",   16'(write_enable),  16'h0000);
    check_output("reset.addr", 16'(write_address), 16'h0100);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic trigger();
    step("trig_neg", 1'b1, 16'h8000, 1'b0);
    step("trig_pos", 1'b1, 16'h0000, 1'b0);
  endtask

  initial begin
    int writes;
    vecs[0] = '{1'b1, 16'h0100, 1'b0, 1'b0, 9'h100, 8'h81};
    vecs[1] = '{1'b1, 16'h0200, 1'b0, 1'b0, 9'h100, 8'h82};
    vecs[2] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 9'h100, 8'h7F};
    vecs[3] = '{1'b1, 16'h0010, 1'b0, 1'b0, 9'h100, 8'h80};
    vecs[4] = '{1'b1, 16'h1234, 1'b0, 1'b1, 9'h100, 8'h92};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 9'h101, 8'h80};

    model_reset();
    #2;
    check_output("reset_init.we",   16'(write_enable),  16'h0000);
    check_output("reset_init.addr", 16'(write_address), 16'h0100);
    do_reset();

    // Directed table: no trigger without a prior negative, then a clean trigger.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].nsr, vecs[i].smp, vecs[i].idle);
      check_output($sformatf("vec%0d.we", i),   16'(write_enable),  16'(vecs[i].exp_we));
      check_output($sformatf("vec%0d.addr", i), 16'(write_address), 16'(vecs[i].exp_addr));
      check_output($sformatf("vec%0d.ws", i),   16'(write_sample),  16'(vecs[i].exp_ws));
      commit_cycle();
    end

    // Full capture of 256 samples into the upper half, then the 257th is dropped.
    do_reset();
    trigger();
    writes = 0;
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(1'b1, 16'(i << 8), 1'b0);
      check_output("fill.addr", 16'(write_address), 16'(9'h100 + i));
      if (write_enable) writes++;
      commit_cycle();
    end
    check_output("fill.count", 16'(writes), 16'd256);
    apply_stimulus(1'b1, 16'h7F00, 1'b0);
    check_output("extra.we",   16'(write_enable),  16'h0000);
    check_output("extra.addr", 16'(write_address), 16'h0100);
    commit_cycle();

    // Hold in WAIT, then swap with a coincident negative sample that must be ignored.
    for (int i = 0; i < 50; i++) step("wait_hold", 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    check_output("wait.ri", 16'(read_index), 16'h0000);
    step("swap", 1'b1, 16'h8000, 1'b1);
    check_output("swap.ri",   16'(read_index),    16'h0001);
    check_output("swap.addr", 16'(write_address), 16'h0000);
    step("no_trig", 1'b1, 16'h0000, 1'b0);
    step("no_trig2", 1'b1, 16'h0100, 1'b0);
    trigger();
    apply_stimulus(1'b1, 16'h4000, 1'b0);
    check_output("lower.we",   16'(write_enable),  16'h0001);
    check_output("lower.addr", 16'(write_address), 16'h0000);
    commit_cycle();

    // Three back-to-back samples land at consecutive addresses.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 16'h0100, 1'b0);
      check_output("burst.we",   16'(write_enable),  16'h0001);
      check_output("burst.addr", 16'(write_address), 16'(1 + i));
      commit_cycle();
    end

    // Asynchronous reset mid-capture drops the strobe before the next edge.
    do_reset();
    trigger();
    for (int i = 0; i < 100; i++) step("pre_abort", 1'b1, 16'(i * 97), 1'b0);
    apply_stimulus(1'b1, 16'h1111, 1'b0);
    check_output("abort.we_before", 16'(write_enable),  16'h0001);
    check_output("abort.addr_before", 16'(write_address), 16'd100 + 16'h0100);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_output("abort.we",   16'(write_enable),  16'h0000);
    check_output("abort.addr", 16'(write_address), 16'h0100);
    check_output("abort.ri",   16'(read_index),    16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_abort", 1'b1, 16'h0200, 1'b0);
    trigger();
    apply_stimulus(1'b1, 16'h2200, 1'b0);
    check_output("restart.we",   16'(write_enable),  16'h0001);
    check_output("restart.addr", 16'(write_address), 16'h0100);
    commit_cycle();

    // Randomized traffic against the model, biased toward frequent zero crossings.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 9) < 4) ? 16'(-int'($urandom_range(1, 3000)))
                                     : 16'($urandom_range(0, 3000));
      if ($urandom_range(0, 7) == 0) s = 16'($urandom);
      step("rand", 1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
